omsp_hmac_absorb_squeeze: RTL and testbench

Hash-side responder for the 16-bit word protocol that the HMAC control FSM drives (`start_continue`, `data_available`, `data_is_long`, `hmac_reset`, `busy`, `data_out`). It packs incoming words into rate-sized blocks and applies word-level 10*1 padding on finalize. It drives the sponge permutation core through a req/ack handshake, then squeezes digest words back one per `start_continue` pulse. It sits between `omsp_hmac_control` and the permutation core inside the Sancus crypto unit.

---
 rtl/omsp_hmac_absorb_squeeze_pkg.sv | 30 +++
 rtl/omsp_hmac_absorb_squeeze_if.sv | 34 +++
 rtl/omsp_hmac_absorb_squeeze_block_buf.sv | 61 ++++++
 rtl/omsp_hmac_absorb_squeeze.sv | 200 ++++++++++++++++++++
 tb/tb_omsp_hmac_absorb_squeeze.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/omsp_hmac_absorb_squeeze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : omsp_hmac_pkg
// Description : Shared state encoding, pad constants and block geometry
//               defaults for the HMAC control / absorb-squeeze pair.
// Revision    : 1.0 - initial release
// ============================================================================
package omsp_hmac_pkg;

  // Geometry defaults shared with omsp_hmac_control
  localparam int C_RATE_WORDS   = 4;
  localparam int C_DIGEST_WORDS = 8;

  // Word-level 10*1 padding constants
  localparam logic [15:0] C_PAD_FIRST  = 16'h8000;
  localparam logic [15:0] C_PAD_MARKER = 16'h0001;
  localparam logic [7:0]  C_PAD_BYTE   = 8'h80;

  // Absorb/squeeze sequencer states
  typedef enum logic [2:0] {
    ST_ABSORB       = 3'd0,
    ST_PERM         = 3'd1,
    ST_PAD_PERM     = 3'd2,
    ST_SQUEEZE      = 3'd3,
    ST_SQUEEZE_PERM = 3'd4,
    ST_DONE         = 3'd5
  } hmac_state_e;

endpackage
`default_nettype wire

// File: rtl/omsp_hmac_absorb_squeeze_if.sv
`default_nettype none
// ============================================================================
// Module      : omsp_hmac_absorb_squeeze_if
// Description : Request/acknowledge bus between the absorb-squeeze responder
//               (master) and the sponge permutation core (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface omsp_hmac_absorb_squeeze_if
  import omsp_hmac_pkg::*;
#(
  parameter int RATE_WORDS = C_RATE_WORDS
);

  logic                      perm_req;
  logic [16*RATE_WORDS-1:0]  perm_absorb;
  logic                      perm_ack;
  logic [16*RATE_WORDS-1:0]  perm_rate;

  modport master (
    output perm_req,
    output perm_absorb,
    input  perm_ack,
    input  perm_rate
  );

  modport slave (
    input  perm_req,
    input  perm_absorb,
    output perm_ack,
    output perm_rate
  );

endinterface
`default_nettype wire

// File: rtl/omsp_hmac_absorb_squeeze_block_buf.sv
`default_nettype none
// ============================================================================
// Module      : omsp_hmac_block_buf
// Description : Word-indexed block register with single-word write, 10*1
//               pad-fill from the write index, final-block marker and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module omsp_hmac_block_buf
  import omsp_hmac_pkg::*;
#(
  parameter int RATE_WORDS = C_RATE_WORDS,
  parameter int IDX_W      = $clog2(RATE_WORDS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         idx,
  input  logic [15:0]              wr_data,
  input  logic                     pad_en,
  input  logic                     padded,
  output logic [16*RATE_WORDS-1:0] block
);

  for (genvar gi = 0; gi < RATE_WORDS; gi++) begin : g_word
    localparam logic [15:0] c_mark = (gi == RATE_WORDS-1) ? C_PAD_MARKER : 16'h0000;

    logic [15:0] r_word;
    logic [15:0] w_pad_word;

    // Pad image: keep data below the write index, 0x8000 at it (unless a short
    // word already padded), zeros above, marker XORed into the last word.
    always_comb begin
      w_pad_word = 16'h0000;
      if (gi < int'(idx)) begin
        w_pad_word = r_word;
      end else if ((gi == int'(idx)) && !padded) begin
        w_pad_word = C_PAD_FIRST;
      end
      w_pad_word = w_pad_word ^ c_mark;
    end

    // Word storage: clear wins over pad-fill, which wins over a data write.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_word <= 16'h0000;
      end else if (clear) begin
        r_word <= 16'h0000;
      end else if (pad_en) begin
        r_word <= w_pad_word;
      end else if (wr_en && (int'(idx) == gi)) begin
        r_word <= wr_data;
      end
    end

    // Word 0 sits in the most significant bits of the block.
    assign block[16*(RATE_WORDS-gi)-1 -: 16] = r_word;
  end

endmodule
`default_nettype wire

// File: rtl/omsp_hmac_absorb_squeeze.sv
`default_nettype none
// ============================================================================
// Module      : omsp_hmac_absorb_squeeze
// Description : Hash-side responder for the HMAC word protocol. Packs words
//               into rate blocks, pads on finalize, drives the permutation
//               core and squeezes digest words back one per command pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module omsp_hmac_absorb_squeeze
  import omsp_hmac_pkg::*;
#(
  parameter int RATE_WORDS   = C_RATE_WORDS,
  parameter int DIGEST_WORDS = C_DIGEST_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hmac_reset,
  input  logic        start_continue,
  input  logic        data_available,
  input  logic        data_is_long,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic [15:0] data_out,
  omsp_hmac_absorb_squeeze_if.master perm
);

  localparam int IDX_W  = $clog2(RATE_WORDS);
  localparam int OIDX_W = $clog2(DIGEST_WORDS + 1);
  localparam int BLK_W  = 16 * RATE_WORDS;

  localparam logic [IDX_W-1:0]  c_last_idx   = IDX_W'(RATE_WORDS - 1);
  localparam logic [OIDX_W-1:0] c_digest_end = OIDX_W'(DIGEST_WORDS);

  hmac_state_e       r_state, w_state_next;
  logic [IDX_W-1:0]  r_widx, w_widx_next;
  logic              r_padded, w_padded_next;
  logic [OIDX_W-1:0] r_oidx, w_oidx_next;
  logic [IDX_W-1:0]  r_ridx, w_ridx_next;
  logic [15:0]       r_data_out, w_data_out_next;
  logic [BLK_W-1:0]  r_sq;
  logic              w_sq_load;
  logic              r_busy_q;
  logic              r_perm_req;
  logic              w_buf_clear, w_buf_wr, w_buf_pad;
  logic [15:0]       w_buf_wdata;
  logic [BLK_W-1:0]  w_block;
  logic              w_in_perm, w_next_in_perm;

  function automatic logic [15:0] word_at(input logic [BLK_W-1:0] blk, input int i);
    return blk[16*(RATE_WORDS-1-i) +: 16];
  endfunction

  omsp_hmac_block_buf #(
    .RATE_WORDS (RATE_WORDS),
    .IDX_W      (IDX_W)
  ) u_block_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_buf_clear),
    .wr_en   (w_buf_wr),
    .idx     (r_widx),
    .wr_data (w_buf_wdata),
    .pad_en  (w_buf_pad),
    .padded  (r_padded),
    .block   (w_block)
  );

  assign w_in_perm = (r_state == ST_PERM) || (r_state == ST_PAD_PERM) ||
                     (r_state == ST_SQUEEZE_PERM);
  assign w_next_in_perm = (w_state_next == ST_PERM) || (w_state_next == ST_PAD_PERM) ||
                          (w_state_next == ST_SQUEEZE_PERM);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ABSORB;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control; message abort overrides every state.
  always_comb begin
    w_state_next    = r_state;
    w_widx_next     = r_widx;
    w_padded_next   = r_padded;
    w_oidx_next     = r_oidx;
    w_ridx_next     = r_ridx;
    w_data_out_next = r_data_out;
    w_sq_load       = 1'b0;
    w_buf_clear     = 1'b0;
    w_buf_wr        = 1'b0;
    w_buf_pad       = 1'b0;
    w_buf_wdata     = data_is_long ? data_in : {data_in[7:0], C_PAD_BYTE};

    if (hmac_reset) begin
      w_state_next    = ST_ABSORB;
      w_widx_next     = '0;
      w_padded_next   = 1'b0;
      w_oidx_next     = '0;
      w_ridx_next     = '0;
      w_data_out_next = 16'h0000;
      w_buf_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_ABSORB: begin
          if (start_continue && data_available) begin
            // Words after the padded short word are dropped silently.
            if (!r_padded) begin
              w_buf_wr = 1'b1;
              if (!data_is_long) begin
                w_padded_next = 1'b1;
              end
              if (r_widx == c_last_idx) begin
                w_widx_next  = '0;
                w_state_next = ST_PERM;
              end else begin
                w_widx_next = r_widx + IDX_W'(1);
              end
            end
          end else if (start_continue) begin
            w_buf_pad    = 1'b1;
            w_state_next = ST_PAD_PERM;
          end
        end
        ST_PERM: begin
          if (perm.perm_ack) begin
            w_buf_clear  = 1'b1;
            w_widx_next  = '0;
            w_state_next = ST_ABSORB;
          end
        end
        ST_PAD_PERM, ST_SQUEEZE_PERM: begin
          if (perm.perm_ack) begin
            w_sq_load       = 1'b1;
            w_data_out_next = word_at(perm.perm_rate, 0);
            w_ridx_next     = '0;
            if (r_state == ST_PAD_PERM) begin
              w_oidx_next = '0;
            end
            w_state_next = ST_SQUEEZE;
          end
        end
        ST_SQUEEZE: begin
          if (start_continue) begin
            w_oidx_next = r_oidx + OIDX_W'(1);
            if (w_oidx_next == c_digest_end) begin
              w_data_out_next = 16'h0000;
              w_state_next    = ST_DONE;
            end else if (r_ridx == c_last_idx) begin
              w_ridx_next  = '0;
              w_state_next = ST_SQUEEZE_PERM;
            end else begin
              w_ridx_next     = r_ridx + IDX_W'(1);
              w_data_out_next = word_at(r_sq, int'(r_ridx) + 1);
            end
          end
        end
        ST_DONE: begin
          w_state_next = ST_DONE;
        end
        default: begin
          w_state_next = ST_ABSORB;
        end
      endcase
    end
  end

  // Datapath registers; perm_req falls on ack or abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_widx     <= '0;
      r_padded   <= 1'b0;
      r_oidx     <= '0;
      r_ridx     <= '0;
      r_data_out <= 16'h0000;
      r_sq       <= '0;
      r_busy_q   <= 1'b0;
      r_perm_req <= 1'b0;
    end else begin
      r_widx     <= w_widx_next;
      r_padded   <= w_padded_next;
      r_oidx     <= w_oidx_next;
      r_ridx     <= w_ridx_next;
      r_data_out <= w_data_out_next;
      if (w_sq_load) begin
        r_sq <= perm.perm_rate;
      end
      r_busy_q   <= w_next_in_perm;
      r_perm_req <= w_in_perm && !perm.perm_ack && !hmac_reset;
    end
  end

  assign busy             = start_continue | r_busy_q;
  assign data_out         = r_data_out;
  assign perm.perm_req    = r_perm_req;
  assign perm.perm_absorb = ((r_state == ST_PERM) || (r_state == ST_PAD_PERM)) ? w_block : '0;

endmodule
`default_nettype wire

// File: tb/tb_omsp_hmac_absorb_squeeze.sv
`default_nettype none
// ============================================================================
// Module      : tb_omsp_hmac_absorb_squeeze
// Description : Directed self-checking bench for omsp_hmac_absorb_squeeze.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_omsp_hmac_absorb_squeeze;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hmac_reset = 1'b0;
  logic        start_continue = 1'b0;
  logic        data_available = 1'b0;
  logic        data_is_long = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        busy;
  logic [15:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  omsp_hmac_absorb_squeeze_if #(.RATE_WORDS(4)) perm_if ();

  omsp_hmac_absorb_squeeze #(
    .RATE_WORDS   (4),
    .DIGEST_WORDS (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hmac_reset     (hmac_reset),
    .start_continue (start_continue),
    .data_available (data_available),
    .data_is_long   (data_is_long),
    .data_in        (data_in),
    .busy           (busy),
    .data_out       (data_out),
    .perm           (perm_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  nwords;
    logic [63:0] words;      // word 0 in the MSBs
    logic [3:0]  long_mask;  // bit i = data_is_long for word i
    logic        full;       // the words fill one block before finalize
    logic [63:0] full_blk;
    logic [63:0] pad_blk;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hreset();
    hmac_reset = 1'b1;
    tick();
    hmac_reset = 1'b0;
    #1;
  endtask

  // One start_continue pulse; checks busy in the pulse cycle and the next.
  task automatic pulse(input logic da, input logic dl, input logic [15:0] din,
                       input logic exp_busy_after, input string name);
    start_continue = 1'b1;
    data_available = da;
    data_is_long   = dl;
    data_in        = din;
    #1;
    chk({name, " busy_pulse"}, 64'(busy), 64'h1);
    tick();
    start_continue = 1'b0;
    data_available = 1'b0;
    data_is_long   = 1'b0;
    #1;
    chk({name, " busy_after"}, 64'(busy), 64'(exp_busy_after));
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!perm_if.perm_req && n < 20) begin
      tick();
      n++;
    end
    chk({name, " perm_req"}, 64'(perm_if.perm_req), 64'h1);
  endtask

  task automatic ack(input logic [63:0] rate);
    perm_if.perm_ack  = 1'b1;
    perm_if.perm_rate = rate;
    tick();
    perm_if.perm_ack = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] w0;
    perm_if.perm_ack  = 1'b0;
    perm_if.perm_rate = '0;

    vecs[0] = '{3'd3, 64'h1111_2222_3333_0000, 4'b0111, 1'b0, 64'h0, 64'h1111_2222_3333_8001};
    vecs[1] = '{3'd4, 64'h1234_5678_9ABC_DEF0, 4'b1111, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001};
    vecs[2] = '{3'd1, 64'h00AB_0000_0000_0000, 4'b0000, 1'b0, 64'h0, 64'hAB80_0000_0000_0001};
    vecs[3] = '{3'd0, 64'h0, 4'b0000, 1'b0, 64'h0, 64'h8000_0000_0000_0001};
    vecs[4] = '{3'd3, 64'hAAAA_BBBB_55CC_0000, 4'b0011, 1'b0, 64'h0, 64'hAAAA_BBBB_CC80_0001};
    vecs[5] = '{3'd3, 64'h1111_0022_3333_0000, 4'b0101, 1'b0, 64'h0, 64'h1111_2280_0000_0001};
    vecs[6] = '{3'd4, 64'h0101_0202_0303_12EE, 4'b0111, 1'b1, 64'h0101_0202_0303_EE80, 64'h0000_0000_0000_0001};
    vecs[7] = '{3'd1, 64'hFFFF_0000_0000_0000, 4'b0001, 1'b0, 64'h0, 64'hFFFF_8000_0000_0001};

    // Reset values
    #2;
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset data_out", 64'(data_out), 64'h0);
    chk("reset perm_req", 64'(perm_if.perm_req), 64'h0);
    chk("reset perm_absorb", perm_if.perm_absorb, 64'h0);
    tick();
    reset = 1'b0;
    tick();

    // Table-driven messages
    for (int v = 0; v < 8; v++) begin
      hreset();
      for (int i = 0; i < 4; i++) begin
        if (i < int'(vecs[v].nwords)) begin
          pulse(1'b1, vecs[v].long_mask[i], vecs[v].words[16*(3-i) +: 16],
                vecs[v].full && (i == 3), $sformatf("v%0d word%0d", v, i));
        end
      end
      if (vecs[v].full) begin
        wait_req($sformatf("v%0d full", v));
        chk($sformatf("v%0d full_block", v), perm_if.perm_absorb, vecs[v].full_blk);
        chk($sformatf("v%0d full busy", v), 64'(busy), 64'h1);
        ack(64'hDEAD_BEEF_DEAD_BEEF);
        chk($sformatf("v%0d post-ack busy", v), 64'(busy), 64'h0);
        chk($sformatf("v%0d post-ack perm_req", v), 64'(perm_if.perm_req), 64'h0);
      end
      pulse(1'b0, 1'b0, 16'h0000, 1'b1, $sformatf("v%0d finalize", v));
      wait_req($sformatf("v%0d pad", v));
      chk($sformatf("v%0d pad_block", v), perm_if.perm_absorb, vecs[v].pad_blk);
      w0 = 16'hC000 + 16'(v);
      ack({w0, 48'h1});
      chk($sformatf("v%0d data_out", v), 64'(data_out), 64'(w0));
      chk($sformatf("v%0d squeeze busy", v), 64'(busy), 64'h0);
    end

    // Full squeeze: 4 words, zero-absorb permutation, 4 words, then DONE
    hreset();
    pulse(1'b1, 1'b1, 16'h1111, 1'b0, "sq w0");
    pulse(1'b1, 1'b1, 16'h2222, 1'b0, "sq w1");
    pulse(1'b1, 1'b1, 16'h3333, 1'b0, "sq w2");
    pulse(1'b0, 1'b0, 16'h0000, 1'b1, "sq fin");
    wait_req("sq pad");
    chk("sq pad_block", perm_if.perm_absorb, 64'h1111_2222_3333_8001);
    ack(64'h1001_1002_1003_1004);
    chk("sq out0", 64'(data_out), 64'h1001);
    pulse(1'b0, 1'b0, 16'h0000, 1'b0, "sq p1");
    chk("sq out1", 64'(data_out), 64'h1002);
    pulse(1'b0, 1'b0, 16'h0000, 1'b0, "sq p2");
    chk("sq out2", 64'(data_out), 64'h1003);
    pulse(1'b0, 1'b0, 16'h0000, 1'b0, "sq p3");
    chk("sq out3", 64'(data_out), 64'h1004);
    pulse(1'b0, 1'b0, 16'h0000, 1'b1, "sq p4");
    wait_req("sq reperm");
    chk("sq reperm absorb", perm_if.perm_absorb, 64'h0);
    ack(64'h2001_2002_2003_2004);
    chk("sq out4", 64'(data_out), 64'h2001);
    pulse(1'b0, 1'b0, 16'h0000, 1'b0, "sq p5");
    chk("sq out5", 64'(data_out), 64'h2002);
    pulse(1'b0, 1'b0, 16'h0000, 1'b0, "sq p6");
    chk("sq out6", 64'(data_out), 64'h2003);
    pulse(1'b0, 1'b0, 16'h0000, 1'b0, "sq p7");
    chk("sq out7", 64'(data_out), 64'h2004);
    pulse(1'b0, 1'b0, 16'h0000, 1'b0, "sq p8");
    chk("sq done out", 64'(data_out), 64'h0);
    pulse(1'b0, 1'b0, 16'h0000, 1'b0, "sq p9");
    chk("sq done out p9", 64'(data_out), 64'h0);
    ack(64'h3333_3333_3333_3333);
    chk("sq done stray ack data_out", 64'(data_out), 64'h0);
    chk("sq done perm_req", 64'(perm_if.perm_req), 64'h0);

    // Abort while a permutation is pending
    hreset();
    pulse(1'b1, 1'b1, 16'hA1A1, 1'b0, "abort w0");
    pulse(1'b1, 1'b1, 16'hA2A2, 1'b0, "abort w1");
    pulse(1'b1, 1'b1, 16'hA3A3, 1'b0, "abort w2");
    pulse(1'b1, 1'b1, 16'hA4A4, 1'b1, "abort w3");
    wait_req("abort perm");
    hreset();
    chk("abort perm_req", 64'(perm_if.perm_req), 64'h0);
    chk("abort busy", 64'(busy), 64'h0);
    ack(64'h4444_4444_4444_4444);
    chk("abort stray perm_req", 64'(perm_if.perm_req), 64'h0);
    chk("abort stray busy", 64'(busy), 64'h0);
    chk("abort stray data_out", 64'(data_out), 64'h0);
    // hmac_reset with a data pulse: the word must not be taken
    start_continue = 1'b1;
    data_available = 1'b1;
    data_is_long   = 1'b1;
    data_in        = 16'h7777;
    hreset();
    start_continue = 1'b0;
    data_available = 1'b0;
    pulse(1'b1, 1'b1, 16'h0A0A, 1'b0, "abort new w0");
    pulse(1'b1, 1'b1, 16'h0B0B, 1'b0, "abort new w1");
    pulse(1'b0, 1'b0, 16'h0000, 1'b1, "abort new fin");
    wait_req("abort new pad");
    chk("abort new pad_block", perm_if.perm_absorb, 64'h0A0A_0B0B_8000_0001);
    ack(64'h5555_0000_0000_0000);

    // Asynchronous reset in the middle of squeezing
    hreset();
    pulse(1'b1, 1'b1, 16'h4242, 1'b0, "ares w0");
    pulse(1'b0, 1'b0, 16'h0000, 1'b1, "ares fin");
    wait_req("ares pad");
    ack(64'h3001_3002_3003_3004);
    pulse(1'b0, 1'b0, 16'h0000, 1'b0, "ares p1");
    chk("ares out1", 64'(data_out), 64'h3002);
    reset = 1'b1;
    #1;
    chk("ares data_out", 64'(data_out), 64'h0);
    chk("ares perm_req", 64'(perm_if.perm_req), 64'h0);
    chk("ares perm_absorb", perm_if.perm_absorb, 64'h0);
    chk("ares busy", 64'(busy), 64'h0);
    tick();
    reset = 1'b0;
    tick();
    pulse(1'b1, 1'b1, 16'h5151, 1'b0, "ares new w0");
    pulse(1'b0, 1'b0, 16'h0000, 1'b1, "ares new fin");
    wait_req("ares new pad");
    chk("ares new pad_block", perm_if.perm_absorb, 64'h5151_8000_0000_0001);
    ack(64'h6000_0000_0000_0000);
    chk("ares new data_out", 64'(data_out), 64'h6000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
